flash_sample_streamer: RTL

- Producer side of the audio sample path. Fetches 32-bit words from flash over a read/waitrequest/readdatavalid interface.
- Splits each word into two 16-bit samples and emits the upper byte of each, one byte per sample_tick.
- The 8-bit stream feeds both the audio output and the intensity meter (meter consumes audio_data directly).
- Supports play/pause, forward/backward direction, restart and address wrap-around.

---
 rtl/flash_stream_pkg.sv | 30 +++
 rtl/flash_addr_ctrl.sv | 31 +++
 rtl/flash_sample_streamer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/flash_stream_pkg.sv
// Shared types and constants for the flash sample streamer.
package flash_stream_pkg;

  localparam int          ADDR_W_DEF   = 23;
  localparam logic [22:0] END_ADDR_DEF = 23'h7FFFF;

  // Byte lanes carrying the upper byte of each 16-bit sample in a flash word
  localparam int SEL_LO_MSB = 15;
  localparam int SEL_LO_LSB = 8;
  localparam int SEL_HI_MSB = 31;
  localparam int SEL_HI_LSB = 24;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ        = 3'd1,
    WAIT_DATA  = 3'd2,
    OUT_FIRST  = 3'd3,
    OUT_SECOND = 3'd4,
    ADVANCE    = 3'd5
  } state_t;

  // Pick the upper byte of the low (hi=0) or high (hi=1) sample of a word
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic hi);
    logic [7:0] b;
    if (hi) b = word[SEL_HI_MSB:SEL_HI_LSB];
    else    b = word[SEL_LO_MSB:SEL_LO_LSB];
    return b;
  endfunction

endpackage

// File: rtl/flash_addr_ctrl.sv
// Flash word-address counter: start-address load, up/down step with wrap.
module flash_addr_ctrl
  import flash_stream_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(END_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_dir,
  input  logic              step,
  input  logic              step_dir,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Load has priority over stepping; backward start is the last word of the song
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_dir ? END_ADDR : '0;
    end else if (step) begin
      if (step_dir) addr <= (addr == '0)       ? END_ADDR : addr - ONE;
      else          addr <= (addr == END_ADDR) ? '0       : addr + ONE;
    end
  end

endmodule

// File: rtl/flash_sample_streamer.sv
// Flash-to-audio sample streamer: fetches 32-bit words from flash and emits
// the upper byte of each 16-bit sample, one per consumed sample_tick.
// Optional build macro STREAMER_UNDERRUN_CNT_EN adds a saturating 16-bit
// dropped-tick counter output (underrun_cnt).
//
// Flash handshake: a read is offered while flash_read=1 with flash_addr held
// stable; it is accepted in the cycle where flash_read=1 and
// flash_waitrequest=0, and flash_read never drops before acceptance. Data
// returns later as a single flash_readdatavalid pulse.
module flash_sample_streamer
  import flash_stream_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(END_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_read,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [7:0]        audio_data,
  output logic              audio_valid,
  output logic              underrun,
`ifdef STREAMER_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
`endif
  output state_t            dbg_state
);

  state_t      state_q, state_d;
  logic        dir_q;
  logic [31:0] word_q;
  logic        pending_q;
  logic        underrun_q;
  logic        discard_q;
  logic        restart_dir_q;
  logic [7:0]  audio_data_q;
  logic        audio_valid_q;

  logic tick;
  logic in_out;
  logic in_fetch;
  logic consume;
  logic restart_jump;
  logic data_ret;
  logic refetch;
  logic drop;
  logic addr_load;
  logic addr_load_dir;
  logic addr_step;

  assign tick         = sample_tick & play;
  assign in_out       = (state_q == OUT_FIRST) || (state_q == OUT_SECOND);
  assign in_fetch     = (state_q == REQ) || (state_q == WAIT_DATA) || (state_q == ADVANCE);
  assign consume      = in_out & play & (sample_tick | pending_q) & ~restart;
  assign restart_jump = restart & ((state_q == IDLE) || in_out || (state_q == ADVANCE));
  assign data_ret     = (state_q == WAIT_DATA) & flash_readdatavalid;
  assign refetch      = data_ret & (discard_q | restart);
  assign drop         = in_fetch & tick & pending_q & ~restart;

  assign addr_load     = restart_jump | refetch;
  assign addr_load_dir = restart ? dir : restart_dir_q;
  assign addr_step     = (state_q == ADVANCE) & ~restart;

  flash_addr_ctrl #(
    .ADDR_W   (ADDR_W),
    .END_ADDR (END_ADDR)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (addr_load),
    .load_dir (addr_load_dir),
    .step     (addr_step),
    .step_dir (dir_q),
    .addr     (flash_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; restart outside a flash transaction jumps straight back
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (play) state_d = REQ;
      REQ:        if (!flash_waitrequest) state_d = WAIT_DATA;
      WAIT_DATA:  if (flash_readdatavalid) state_d = refetch ? REQ : OUT_FIRST;
      OUT_FIRST: begin
        if (restart)      state_d = play ? REQ : IDLE;
        else if (consume) state_d = OUT_SECOND;
      end
      OUT_SECOND: begin
        if (restart)      state_d = play ? REQ : IDLE;
        else if (consume) state_d = ADVANCE;
      end
      ADVANCE:    state_d = (restart && !play) ? IDLE : REQ;
      default:    state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    flash_read  = (state_q == REQ);
    dbg_state   = state_q;
    audio_data  = audio_data_q;
    audio_valid = audio_valid_q;
    underrun    = underrun_q;
  end

  // Word datapath: direction latch, word capture, discard tracking, sample output
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q         <= 1'b0;
      word_q        <= '0;
      discard_q     <= 1'b0;
      restart_dir_q <= 1'b0;
      audio_data_q  <= '0;
      audio_valid_q <= 1'b0;
    end else begin
      if (state_d == REQ && state_q != REQ) dir_q <= dir;
      if (data_ret && !refetch) word_q <= flash_readdata;
      if (restart && (state_q == REQ || (state_q == WAIT_DATA && !flash_readdatavalid))) begin
        discard_q     <= 1'b1;
        restart_dir_q <= dir;
      end else if (data_ret) begin
        discard_q <= 1'b0;
      end
      audio_valid_q <= consume;
      if (consume) audio_data_q <= pick_byte(word_q, (state_q == OUT_SECOND) ^ dir_q);
    end
  end

  // Tick bookkeeping: one tick may wait while fetching; a second one is lost
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else if (consume) begin
      pending_q <= pending_q & tick;
    end else if (in_fetch && tick) begin
      if (pending_q) underrun_q <= 1'b1;
      else           pending_q  <= 1'b1;
    end
  end

`ifdef STREAMER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  // Saturating count of dropped ticks
  always_ff @(posedge clk) begin
    if (reset || restart)                 underrun_cnt_q <= '0;
    else if (drop && underrun_cnt_q != 16'hFFFF) underrun_cnt_q <= underrun_cnt_q + 16'd1;
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
